// File: rtl/layer_sequencer.sv
// layer_sequencer: descriptor-table driven CNN layer schedule controller.
// Walks conv/maxp/dense/result layers, owns ping-pong buffer selection.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_we/addr/data    descriptor table write (IDLE or FINISH only)
//   GO                  start / restart request
//   load_req, load_done weight-load handshake with memorywork
//   conv/maxp/dense/result_en, eng_done  engine enables, pass done
//   res_in              class index from the result engine
//   memstartp_lvl       read base of the current pass
//   memstartzap_num     write base of the current pass
//   memstartw_lvl       weight base of the current pass
//   matrix, lvl, slvl   map side, output / input channel index
//   bias, globmaxp_en   pass modifiers
//   STOP, RESULT        finished flag, captured class (4'hF otherwise)
module layer_sequencer #(
  parameter int MAX_LAYERS       = 16,
  parameter int SIZE_address_pix = 13,
  parameter int SIZE_address_wei = 9,
  parameter int BUF_A            = 0,
  parameter int BUF_B            = 3136
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(MAX_LAYERS)-1:0] cfg_addr,
  input  logic [18:0]                   cfg_data,
  input  logic                          GO,
  output logic                          load_req,
  input  logic                          load_done,
  output logic                          conv_en,
  output logic                          maxp_en,
  output logic                          dense_en,
  output logic                          result_en,
  input  logic                          eng_done,
  input  logic [3:0]                    res_in,
  output logic [SIZE_address_pix-1:0]   memstartp_lvl,
  output logic [SIZE_address_pix-1:0]   memstartzap_num,
  output logic [SIZE_address_wei-1:0]   memstartw_lvl,
  output logic [4:0]                    matrix,
  output logic [4:0]                    lvl,
  output logic [4:0]                    slvl,
  output logic                          bias,
  output logic                          globmaxp_en,
  output logic                          STOP,
  output logic [3:0]                    RESULT
);

  localparam int AW = $clog2(MAX_LAYERS);
  localparam int PW = SIZE_address_pix;
  localparam int WW = SIZE_address_wei;

  typedef enum logic [1:0] {
    OP_CONV  = 2'd0,
    OP_MAXP  = 2'd1,
    OP_DENSE = 2'd2,
    OP_RES   = 2'd3
  } op_e;

  typedef struct packed {
    logic       last;
    logic       gmp;
    logic [4:0] och;
    logic [4:0] ich;
    logic [4:0] mat;
    op_e        op;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_FIN
  } state_t;

  desc_t         tbl_q [MAX_LAYERS];
  desc_t         fetched;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ping_q, ping_d;
  desc_t         desc_q, desc_d;
  logic [4:0]    lvl_q, lvl_d;
  logic [4:0]    slvl_q, slvl_d;
  logic [3:0]    en_q, en_d;
  logic          load_q, load_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [WW-1:0] w_q, w_d;
  logic          bias_q, bias_d;
  logic          gmp_q, gmp_d;
  logic          stop_q, stop_d;
  logic [3:0]    res_q, res_d;

  logic          cfg_open;
  logic          layer_end;
  logic [9:0]    m2;
  logic [PW-1:0] in_base, out_base;
  logic [PW-1:0] rd_addr, wr_addr;
  logic [WW-1:0] w_addr;

  // Descriptor table: not reset, frozen while a schedule runs.
  assign cfg_open = (state_q == S_IDLE) || (state_q == S_FIN);

  always_ff @(posedge clk) begin
    if (cfg_we && cfg_open) begin
      tbl_q[cfg_addr] <= desc_t'(cfg_data);
    end
  end

  assign fetched = tbl_q[ptr_q];

  // Pass addressing from the latched descriptor and channel counters.
  always_comb begin
    m2       = {5'd0, desc_q.mat} * {5'd0, desc_q.mat};
    in_base  = ping_q ? PW'(BUF_B) : PW'(BUF_A);
    out_base = ping_q ? PW'(BUF_A) : PW'(BUF_B);
    rd_addr  = in_base;
    wr_addr  = out_base;
    w_addr   = '0;
    unique case (desc_q.op)
      OP_CONV: begin
        rd_addr = in_base + PW'(slvl_q) * PW'(m2);
        if (desc_q.gmp) begin
          wr_addr = out_base + PW'(lvl_q);
        end else begin
          wr_addr = out_base + PW'(lvl_q) * PW'(m2);
        end
        w_addr = WW'(lvl_q)
               + WW'(slvl_q) * WW'({1'b0, desc_q.och} + 6'd1);
      end
      OP_MAXP: begin
        rd_addr = in_base + PW'(lvl_q) * PW'(m2);
        wr_addr = out_base + PW'(lvl_q) * PW'(m2 >> 2);
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ping_d    = ping_q;
    desc_d    = desc_q;
    lvl_d     = lvl_q;
    slvl_d    = slvl_q;
    en_d      = '0;
    load_d    = 1'b0;
    rd_d      = rd_q;
    wr_d      = wr_q;
    w_d       = w_q;
    bias_d    = bias_q;
    gmp_d     = gmp_q;
    stop_d    = stop_q;
    res_d     = res_q;
    layer_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (GO) begin
          ptr_d   = '0;
          ping_d  = 1'b0;
          stop_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        desc_d = fetched;
        lvl_d  = '0;
        slvl_d = '0;
        if (fetched.op == OP_CONV || fetched.op == OP_DENSE) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_LOAD: begin
        if (load_done) begin
          state_d = S_ISSUE;
        end else begin
          load_d = 1'b1;
        end
      end
      S_ISSUE: begin
        en_d    = 4'b0001 << desc_q.op;
        rd_d    = rd_addr;
        wr_d    = wr_addr;
        w_d     = w_addr;
        bias_d  = (desc_q.op == OP_CONV) && (slvl_q == desc_q.ich);
        gmp_d   = (desc_q.op == OP_CONV) && desc_q.gmp;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        en_d = en_q;
        if (eng_done) begin
          en_d    = '0;
          state_d = S_ADV;
          if (desc_q.op == OP_RES) begin
            res_d = res_in;
          end
        end
      end
      S_ADV: begin
        // conv: slvl inner, lvl outer; maxp: lvl only.
        unique case (desc_q.op)
          OP_CONV: begin
            if (slvl_q != desc_q.ich) begin
              slvl_d  = slvl_q + 5'd1;
              state_d = S_ISSUE;
            end else if (lvl_q != desc_q.och) begin
              slvl_d  = '0;
              lvl_d   = lvl_q + 5'd1;
              state_d = S_ISSUE;
            end else begin
              layer_end = 1'b1;
            end
          end
          OP_MAXP: begin
            if (lvl_q != desc_q.ich) begin
              lvl_d   = lvl_q + 5'd1;
              state_d = S_ISSUE;
            end else begin
              layer_end = 1'b1;
            end
          end
          default: layer_end = 1'b1;
        endcase
        if (layer_end) begin
          if (desc_q.op == OP_RES || desc_q.last
              || ptr_q == AW'(MAX_LAYERS - 1)) begin
            stop_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            ping_d  = ~ping_q;
            state_d = S_FETCH;
          end
        end
      end
      S_FIN: begin
        if (GO) begin
          stop_d  = 1'b0;
          res_d   = 4'hF;
          ptr_d   = '0;
          ping_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      ping_q  <= 1'b0;
      desc_q  <= '0;
      lvl_q   <= '0;
      slvl_q  <= '0;
      en_q    <= '0;
      load_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      w_q     <= '0;
      bias_q  <= 1'b0;
      gmp_q   <= 1'b0;
      stop_q  <= 1'b0;
      res_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ping_q  <= ping_d;
      desc_q  <= desc_d;
      lvl_q   <= lvl_d;
      slvl_q  <= slvl_d;
      en_q    <= en_d;
      load_q  <= load_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      w_q     <= w_d;
      bias_q  <= bias_d;
      gmp_q   <= gmp_d;
      stop_q  <= stop_d;
      res_q   <= res_d;
    end
  end

  assign load_req        = load_q;
  assign conv_en         = en_q[0];
  assign maxp_en         = en_q[1];
  assign dense_en        = en_q[2];
  assign result_en       = en_q[3];
  assign memstartp_lvl   = rd_q;
  assign memstartzap_num = wr_q;
  assign memstartw_lvl   = w_q;
  assign matrix          = desc_q.mat;
  assign lvl             = lvl_q;
  assign slvl            = slvl_q;
  assign bias            = bias_q;
  assign globmaxp_en     = gmp_q;
  assign STOP            = stop_q;
  assign RESULT          = res_q;

endmodule
